// File: rtl/oled_pkg.sv
// Shared constants and state encoding for the SSD1306 frame streaming path.
// Command/data control bytes follow the SSD1306 I2C control-byte format.
package oled_pkg;

    localparam logic [7:0] CTRL_CMD           = 8'h00;
    localparam logic [7:0] CTRL_DATA          = 8'h40;
    localparam logic [7:0] CMD_COL_ADDR       = 8'h21;
    localparam logic [7:0] CMD_PAGE_ADDR      = 8'h22;
    localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h3C;

    localparam int unsigned CMD_IDX_W = 3;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StFetch,
        StWait,
        StData,
        StErr
    } streamer_state_e;

endpackage

// File: rtl/oled_addr_cmd_rom.sv
// Column/page addressing command bytes that reset the SSD1306 write window
// to the full panel; last flags the final byte of the command transaction.
module oled_addr_cmd_rom
    import oled_pkg::*;
#(
    parameter int unsigned COLS  = 128,
    parameter int unsigned PAGES = 8
) (
    input  logic [CMD_IDX_W-1:0] idx,
    output logic [7:0]           cmd_byte,
    output logic                 last
);

    always_comb begin
        cmd_byte = 8'h00;
        last     = 1'b0;
        case (idx)
            3'd0: cmd_byte = CMD_COL_ADDR;
            3'd1: cmd_byte = 8'h00;
            3'd2: cmd_byte = 8'(COLS - 1);
            3'd3: cmd_byte = CMD_PAGE_ADDR;
            3'd4: cmd_byte = 8'h00;
            3'd5: begin
                cmd_byte = 8'(PAGES - 1);
                last     = 1'b1;
            end
            default: begin
                cmd_byte = 8'h00;
                last     = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/oled_frame_streamer.sv
// Streams a full framebuffer to the SSD1306 through i2c_master's byte handshake.
// Define OLED_STREAMER_ADDR_CMD_EN to prefix each frame with the addressing commands.
module oled_frame_streamer
    import oled_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDR = DEFAULT_SLAVE_ADDR,
    parameter int unsigned COLS       = 128,
    parameter int unsigned PAGES      = 8,
    parameter int unsigned AW         = $clog2(COLS * PAGES)
) (
    input  logic          CLK,
    input  logic          NRST,
    input  logic          init_done,
    input  logic          frame_start,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_data,
    output logic [6:0]    slave_addr,
    output logic          read_write,
    output logic [7:0]    control_frame,
    output logic [7:0]    data_write,
    output logic          xfer_valid,
    input  logic          xfer_ready,
    output logic          xfer_stop,
    input  logic          xfer_nack,
    output logic          busy,
    output logic          frame_done,
    output logic          error
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(COLS * PAGES - 1);

    streamer_state_e      state;
    logic [CMD_IDX_W-1:0] cmd_idx;
    logic [CMD_IDX_W-1:0] rom_idx;
    logic [7:0]           rom_byte;
    logic                 rom_last;
    logic                 accept;
    logic                 nack_active;

    assign slave_addr  = SLAVE_ADDR;
    assign read_write  = 1'b0;
    assign accept      = xfer_valid && xfer_ready;
    assign nack_active = xfer_nack && (state != StIdle) && (state != StErr);

    // ROM looks one entry ahead so the next command byte is ready on acceptance.
    assign rom_idx = (state == StCmd) ? cmd_idx + 3'd1 : 3'd0;

    oled_addr_cmd_rom #(
        .COLS  (COLS),
        .PAGES (PAGES)
    ) u_addr_cmd_rom (
        .idx      (rom_idx),
        .cmd_byte (rom_byte),
        .last     (rom_last)
    );

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            state         <= StIdle;
            cmd_idx       <= '0;
            mem_addr      <= '0;
            data_write    <= 8'h00;
            control_frame <= CTRL_CMD;
            xfer_valid    <= 1'b0;
            xfer_stop     <= 1'b0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            error         <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (nack_active) begin
                // A NACK aborts the frame even if the same byte was accepted.
                state      <= StErr;
                xfer_valid <= 1'b0;
                error      <= 1'b1;
            end else begin
                unique case (state)
                    StIdle: begin
                        if (frame_start && init_done) begin
                            busy     <= 1'b1;
                            error    <= 1'b0;
                            mem_addr <= '0;
`ifdef OLED_STREAMER_ADDR_CMD_EN
                            state         <= StCmd;
                            cmd_idx       <= '0;
                            data_write    <= rom_byte;
                            control_frame <= CTRL_CMD;
                            xfer_stop     <= rom_last;
                            xfer_valid    <= 1'b1;
`else
                            state <= StFetch;
`endif
                        end
                    end
                    StCmd: begin
                        if (accept) begin
                            if (xfer_stop) begin
                                xfer_valid <= 1'b0;
                                xfer_stop  <= 1'b0;
                                state      <= StFetch;
                            end else begin
                                cmd_idx    <= cmd_idx + 3'd1;
                                data_write <= rom_byte;
                                xfer_stop  <= rom_last;
                            end
                        end
                    end
                    StFetch: begin
                        state <= StWait;
                    end
                    StWait: begin
                        data_write    <= mem_data;
                        control_frame <= CTRL_DATA;
                        xfer_stop     <= (mem_addr == LAST_ADDR);
                        xfer_valid    <= 1'b1;
                        state         <= StData;
                    end
                    StData: begin
                        if (accept) begin
                            xfer_valid <= 1'b0;
                            if (xfer_stop) begin
                                frame_done <= 1'b1;
                                busy       <= 1'b0;
                                mem_addr   <= '0;
                                state      <= StIdle;
                            end else begin
                                mem_addr <= mem_addr + AW'(1);
                                state    <= StFetch;
                            end
                        end
                    end
                    StErr: begin
                        busy  <= 1'b0;
                        state <= StIdle;
                    end
                    default: begin
                        state <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_oled_frame_streamer.sv
// Directed bench for oled_frame_streamer: table of frame scenarios plus
// hand-written reset, latency and ignored-request sequences.
module tb_oled_frame_streamer;

`ifdef OLED_STREAMER_ADDR_CMD_EN
    localparam int NCMD = 6;
`else
    localparam int NCMD = 0;
`endif
    localparam int NDATA  = 1024;
    localparam int TOTAL  = NCMD + NDATA;
    localparam int BUDGET = 60000;

    typedef struct {
        int stall_max;
        int nack_at;
        int start_at;
        int rst_at;
        int exp_bytes;
        int exp_done;
        int exp_error;
    } scen_t;

    logic       clk;
    logic       rst_n;
    logic       init_done;
    logic       frame_start;
    logic [9:0] mem_addr;
    logic [7:0] mem_data;
    logic [6:0] slave_addr;
    logic       read_write;
    logic [7:0] control_frame;
    logic [7:0] data_write;
    logic       xfer_valid;
    logic       xfer_ready;
    logic       xfer_stop;
    logic       xfer_nack;
    logic       busy;
    logic       frame_done;
    logic       error;

    logic [7:0] ram [NDATA];
    logic [7:0] cmd_tbl [6];
    scen_t      tbl [9];

    int checks;
    int errors;

    oled_frame_streamer dut (
        .CLK           (clk),
        .NRST          (rst_n),
        .init_done     (init_done),
        .frame_start   (frame_start),
        .mem_addr      (mem_addr),
        .mem_data      (mem_data),
        .slave_addr    (slave_addr),
        .read_write    (read_write),
        .control_frame (control_frame),
        .data_write    (data_write),
        .xfer_valid    (xfer_valid),
        .xfer_ready    (xfer_ready),
        .xfer_stop     (xfer_stop),
        .xfer_nack     (xfer_nack),
        .busy          (busy),
        .frame_done    (frame_done),
        .error         (error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous framebuffer: data valid one cycle after the address.
    always @(posedge clk) mem_data <= ram[mem_addr];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // {stop, control, byte} expected at stream position k.
    function automatic logic [16:0] exp_for(input int k);
        int a;
        if (k < NCMD) return {(k == NCMD - 1), 8'h00, cmd_tbl[k]};
        a = k - NCMD;
        return {(a == NDATA - 1), 8'h40, ram[a]};
    endfunction

    task automatic check_reset_outputs(input string name);
        check(name, 64'({xfer_valid, busy, frame_done, error, mem_addr, data_write,
                         control_frame, xfer_stop, read_write, slave_addr}),
              64'({1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 8'h00, 8'h00, 1'b0, 1'b0, 7'h3C}));
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    // Runs the master side until busy drops; entered and left on a negedge.
    task automatic stream(input scen_t s, output int nbytes, output int ndone);
        logic [16:0] held;
        bit          pending;
        bit          timed_out;
        int          stall;
        nbytes    = 0;
        ndone     = 0;
        pending   = 1'b0;
        timed_out = 1'b1;
        stall     = 0;
        held      = '0;
        for (int cyc = 0; cyc < BUDGET; cyc++) begin
            xfer_ready  = 1'b0;
            xfer_nack   = 1'b0;
            frame_start = 1'b0;
            if (frame_done) begin
                ndone++;
                check("done_busy_low", 64'(busy), 64'd0);
            end
            if (!busy) begin
                timed_out = 1'b0;
                break;
            end
            if (pending) begin
                check("valid_held", 64'(xfer_valid), 64'd1);
                if (xfer_valid)
                    check("offer_stable", 64'({xfer_stop, control_frame, data_write}), 64'(held));
            end
            if (s.rst_at == nbytes && xfer_valid) begin
                rst_n = 1'b0;
                #1;
                check_reset_outputs("async_reset_outputs");
                @(negedge clk);
                rst_n     = 1'b1;
                timed_out = 1'b0;
                break;
            end
            if (s.start_at == nbytes && xfer_valid && !pending) frame_start = 1'b1;
            if (xfer_valid) begin
                if (!pending) stall = (s.stall_max > 0) ? $urandom_range(0, s.stall_max) : 0;
                if (nbytes == s.nack_at) begin
                    xfer_nack  = 1'b1;
                    xfer_ready = 1'b1;
                    pending    = 1'b0;
                end else if (stall > 0) begin
                    stall--;
                    pending = 1'b1;
                    held    = {xfer_stop, control_frame, data_write};
                end else begin
                    xfer_ready = 1'b1;
                    check($sformatf("byte%0d", nbytes),
                          64'({xfer_stop, control_frame, data_write}), 64'(exp_for(nbytes)));
                    nbytes++;
                    pending = 1'b0;
                end
            end else begin
                pending = 1'b0;
            end
            @(negedge clk);
        end
        xfer_ready  = 1'b0;
        xfer_nack   = 1'b0;
        frame_start = 1'b0;
        if (timed_out) check("stream_timeout", 64'd1, 64'd0);
    endtask

    task automatic finish_frame(input string tag, input scen_t s, input int nbytes,
                                input int ndone);
        check({tag, "_bytes"}, 64'(nbytes), 64'(s.exp_bytes));
        check({tag, "_done"}, 64'(ndone), 64'(s.exp_done));
        check({tag, "_error"}, 64'(error), 64'(s.exp_error));
        if (s.exp_done != 0) check({tag, "_addr_wrap"}, 64'(mem_addr), 64'd0);
        repeat (5) @(negedge clk);
        check({tag, "_stays_idle"}, 64'({busy, xfer_valid}), 64'd0);
    endtask

    initial begin
        int    nb;
        int    nd;
        scen_t s0;
        checks = 0;
        errors = 0;
        for (int i = 0; i < NDATA; i++) ram[i] = 8'((i * 37 + 11) ^ (i >> 4));
        cmd_tbl = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};

        //          stall nack       start      rst        bytes      done err
        tbl[0] = '{50, -1,        -1,        -1,        TOTAL,        1, 0};
        tbl[1] = '{0,  NCMD + 300, -1,       -1,        NCMD + 300,   0, 1};
        tbl[2] = '{0,  -1,        -1,        -1,        TOTAL,        1, 0};
        tbl[3] = '{2,  -1,        NCMD + 40, -1,        TOTAL,        1, 0};
        tbl[4] = '{0,  NCMD + 1023, -1,      -1,        NCMD + 1023,  0, 1};
        tbl[5] = '{0,  -1,        -1,        NCMD + 500, NCMD + 500,  0, 0};
        tbl[6] = '{0,  -1,        -1,        -1,        TOTAL,        1, 0};
        tbl[7] = '{1,  1,         -1,        -1,        1,            0, 1};
        tbl[8] = '{3,  -1,        -1,        -1,        TOTAL,        1, 0};

        rst_n       = 1'b0;
        init_done   = 1'b0;
        frame_start = 1'b0;
        xfer_ready  = 1'b0;
        xfer_nack   = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_values");
        rst_n = 1'b1;
        @(negedge clk);

        // Request without init_done is dropped.
        pulse_start();
        repeat (3) @(negedge clk);
        check("no_init_ignored", 64'({busy, xfer_valid}), 64'd0);

        // First frame: start latency, then full stream with master always ready.
        init_done = 1'b1;
        pulse_start();
        check("start_busy", 64'({busy, error, mem_addr}), 64'({1'b1, 1'b0, 10'd0}));
`ifdef OLED_STREAMER_ADDR_CMD_EN
        check("first_offer", 64'({xfer_valid, xfer_stop, control_frame, data_write}),
              64'({1'b1, 1'b0, 8'h00, 8'h21}));
`else
        check("lat_cycle1", 64'(xfer_valid), 64'd0);
        @(negedge clk);
        check("lat_cycle2", 64'(xfer_valid), 64'd0);
        @(negedge clk);
        check("first_offer", 64'({xfer_valid, xfer_stop, control_frame, data_write}),
              64'({1'b1, 1'b0, 8'h40, ram[0]}));
`endif
        s0 = '{0, -1, -1, -1, TOTAL, 1, 0};
        stream(s0, nb, nd);
        finish_frame("frame0", s0, nb, nd);

        for (int i = 0; i < 9; i++) begin
            pulse_start();
            check($sformatf("scen%0d_start", i), 64'({busy, error}), 64'({1'b1, 1'b0}));
            stream(tbl[i], nb, nd);
            finish_frame($sformatf("scen%0d", i), tbl[i], nb, nd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
